// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: decoded operand/destination info in, forwarding tags and
// stall/bubble control out.
interface hazard_scoreboard_if;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       id_multi;
    logic       flush;
    logic       stall;
    logic       bubble;
    logic [4:0] rdidex;
    logic       rwriteidex;
    logic [4:0] rdexmem;
    logic       rwriteexmem;
    logic [4:0] rdmemwb;
    logic       rwritememwb;
    logic       multi_busy;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread, id_multi, flush,
        input  stall, bubble, rdidex, rwriteidex, rdexmem, rwriteexmem,
               rdmemwb, rwritememwb, multi_busy
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread, id_multi, flush,
        output stall, bubble, rdidex, rwriteidex, rdexmem, rwriteexmem,
               rdmemwb, rwritememwb, multi_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks destination tags through ID/EX, EX/MEM and MEM/WB and generates load-use and
// multi-cycle EX stall/bubble control.
module hazard_scoreboard #(
    parameter int MULDIV_LAT = 4
) (
    input logic               clk,
    input logic               rst,
    hazard_scoreboard_if.slave hz
);
    localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_LAT - 1);

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
        logic       multi;
    } idex_tag_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
    } wb_tag_t;

    idex_tag_t        idex_p0;
    wb_tag_t          exmem_p1;
    wb_tag_t          memwb_p2;
    logic [CNT_W-1:0] cnt;

    logic      ex_hold;
    logic      loaduse;
    logic      rs1_hit;
    logic      rs2_hit;
    idex_tag_t id_tag;

    always_comb begin
        ex_hold = idex_p0.multi && (cnt != CNT_LAST);
        rs1_hit = hz.id_use_rs1 && (hz.id_rs1 == idex_p0.rd);
        rs2_hit = hz.id_use_rs2 && (hz.id_rs2 == idex_p0.rd);
        loaduse = hz.id_valid && idex_p0.memread && idex_p0.regwrite && (rs1_hit || rs2_hit);
        // x0 never carries a live result, so its regwrite is dropped at capture
        id_tag.rd       = hz.id_rd;
        id_tag.regwrite = hz.id_regwrite && (hz.id_rd != 5'd0);
        id_tag.memread  = hz.id_memread;
        id_tag.multi    = hz.id_multi;
    end

    assign hz.stall       = hz.id_valid && !hz.flush && (ex_hold || loaduse);
    assign hz.bubble      = !hz.flush && !ex_hold && loaduse;
    assign hz.multi_busy  = ex_hold;
    assign hz.rdidex      = idex_p0.rd;
    assign hz.rwriteidex  = idex_p0.regwrite;
    assign hz.rdexmem     = exmem_p1.rd;
    assign hz.rwriteexmem = exmem_p1.regwrite;
    assign hz.rdmemwb     = memwb_p2.rd;
    assign hz.rwritememwb = memwb_p2.regwrite;

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_p0  <= '0;
            exmem_p1 <= '0;
            memwb_p2 <= '0;
            cnt      <= '0;
        end else begin
            // ---- EX/MEM -> MEM/WB ----
            memwb_p2 <= exmem_p1;
            // ---- ID/EX -> EX/MEM ----
            if (ex_hold) begin
                cnt      <= cnt + 1'b1;
                exmem_p1 <= '0;
            end else begin
                cnt      <= '0;
                exmem_p1 <= '{rd: idex_p0.rd, regwrite: idex_p0.regwrite};
                // ---- ID -> ID/EX ----
                if (hz.flush || loaduse || !hz.id_valid)
                    idex_p0 <= '0;
                else
                    idex_p0 <= id_tag;
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations (MULDIV_LAT=4).
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    hazard_scoreboard_if hz ();

    hazard_scoreboard #(.MULDIV_LAT(4)) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                          input logic mu, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        hz.id_valid    = v;
        hz.id_rd       = rd;
        hz.id_regwrite = rw;
        hz.id_memread  = mr;
        hz.id_multi    = mu;
        hz.id_rs1      = rs1;
        hz.id_use_rs1  = u1;
        hz.id_rs2      = rs2;
        hz.id_use_rs2  = u2;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        hz.flush = 1'b0;
        // Reset held for two edges with a valid x5 writer in ID
        rst = 1'b1;
        set_id(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        tick();
        chk("rst_rdidex", 8'(hz.rdidex), 8'd0);
        chk("rst_rwidex", 8'(hz.rwriteidex), 8'd0);
        chk("rst_rdexmem", 8'(hz.rdexmem), 8'd0);
        chk("rst_rdmemwb", 8'(hz.rdmemwb), 8'd0);
        chk("rst_stall", 8'(hz.stall), 8'd0);
        chk("rst_busy", 8'(hz.multi_busy), 8'd0);
        rst = 1'b0;
        tick();
        chk("rel_rdidex", 8'(hz.rdidex), 8'd5);
        chk("rel_rwidex", 8'(hz.rwriteidex), 8'd1);
        idle();
        repeat (3) tick();

        // ALU chain: add x3 ; add x4, x3
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1 chk("alu_stall0", 8'(hz.stall), 8'd0);
        tick();
        chk("alu_rdidex3", 8'(hz.rdidex), 8'd3);
        set_id(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        #1 chk("alu_stall1", 8'(hz.stall), 8'd0);
        tick();
        chk("alu_rdidex4", 8'(hz.rdidex), 8'd4);
        chk("alu_rdexmem3", 8'(hz.rdexmem), 8'd3);
        chk("alu_rwexmem", 8'(hz.rwriteexmem), 8'd1);
        idle();
        tick();
        chk("alu_rdmemwb3", 8'(hz.rdmemwb), 8'd3);
        chk("alu_rwmemwb", 8'(hz.rwritememwb), 8'd1);
        chk("alu_rdexmem4", 8'(hz.rdexmem), 8'd4);
        repeat (3) tick();

        // Load-use: lw x7 ; add x8, .., x7
        set_id(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("lu_rdidex7", 8'(hz.rdidex), 8'd7);
        set_id(1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 5'd7, 1'b1);
        #1 chk("lu_stall", 8'(hz.stall), 8'd1);
        chk("lu_bubble", 8'(hz.bubble), 8'd1);
        tick();
        chk("lu_rwidex0", 8'(hz.rwriteidex), 8'd0);
        chk("lu_rdexmem7", 8'(hz.rdexmem), 8'd7);
        #1 chk("lu_stall_off", 8'(hz.stall), 8'd0);
        chk("lu_bubble_off", 8'(hz.bubble), 8'd0);
        tick();
        chk("lu_rdidex8", 8'(hz.rdidex), 8'd8);
        chk("lu_rwidex8", 8'(hz.rwriteidex), 8'd1);
        idle();
        repeat (3) tick();

        // x0 destination load followed by x0 uses
        set_id(1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("x0_rwidex", 8'(hz.rwriteidex), 8'd0);
        set_id(1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1 chk("x0_stall", 8'(hz.stall), 8'd0);
        chk("x0_bubble", 8'(hz.bubble), 8'd0);
        tick();
        chk("x0_rwexmem", 8'(hz.rwriteexmem), 8'd0);
        chk("x0_rdidex10", 8'(hz.rdidex), 8'd10);
        idle();
        tick();
        chk("x0_rwmemwb", 8'(hz.rwritememwb), 8'd0);
        repeat (3) tick();

        // Multi-cycle: mul x9 followed by independent add x11
        set_id(1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("mul_rdidex9", 8'(hz.rdidex), 8'd9);
        chk("mul_busy0", 8'(hz.multi_busy), 8'd1);
        set_id(1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1 chk("mul_stall0", 8'(hz.stall), 8'd1);
        chk("mul_bubble0", 8'(hz.bubble), 8'd0);
        tick();
        chk("mul_busy1", 8'(hz.multi_busy), 8'd1);
        chk("mul_stall1", 8'(hz.stall), 8'd1);
        chk("mul_exmem_bub1", 8'(hz.rwriteexmem), 8'd0);
        chk("mul_hold_idex", 8'(hz.rdidex), 8'd9);
        tick();
        chk("mul_busy2", 8'(hz.multi_busy), 8'd1);
        chk("mul_stall2", 8'(hz.stall), 8'd1);
        tick();
        chk("mul_busy3", 8'(hz.multi_busy), 8'd0);
        chk("mul_stall3", 8'(hz.stall), 8'd0);
        tick();
        chk("mul_rdexmem9", 8'(hz.rdexmem), 8'd9);
        chk("mul_rwexmem", 8'(hz.rwriteexmem), 8'd1);
        chk("mul_rdidex11", 8'(hz.rdidex), 8'd11);
        idle();
        repeat (3) tick();

        // Flush coinciding with load-use
        set_id(1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0);
        hz.flush = 1'b1;
        #1 chk("fl_stall", 8'(hz.stall), 8'd0);
        chk("fl_bubble", 8'(hz.bubble), 8'd0);
        tick();
        hz.flush = 1'b0;
        idle();
        chk("fl_rdidex0", 8'(hz.rdidex), 8'd0);
        chk("fl_rwidex0", 8'(hz.rwriteidex), 8'd0);
        chk("fl_rdexmem12", 8'(hz.rdexmem), 8'd12);
        chk("fl_rwexmem", 8'(hz.rwriteexmem), 8'd1);
        repeat (3) tick();

        // Reset in the middle of a multi-cycle op discards it
        set_id(1'b1, 5'd14, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        idle();
        tick();
        chk("mrst_busy_pre", 8'(hz.multi_busy), 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", 8'(hz.multi_busy), 8'd0);
        chk("mrst_rdidex", 8'(hz.rdidex), 8'd0);
        tick();
        chk("mrst_rwexmem", 8'(hz.rwriteexmem), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
